dna_mem_loader: RTL and testbench

//  Sequencer that fills the memory bank before an alignment run. Accepts one word stream
//  (valid/ready), writes the first read_len words into the read memory and the next ref_len

---
 rtl/dna_mem_loader.sv | 187 ++++++++++++++++++
 tb/tb_dna_mem_loader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dna_mem_loader.sv
// Load sequencer: streams read/ref words into their memories, then
// zero-clears every matrix bank and pulses done.
module dna_mem_loader #(
    parameter int MEM_SIZE   = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 8,
    parameter int N_MATRIX   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      read_len,
    input  logic [LEN_W-1:0]      ref_len,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  we_read,
    output logic [ADDR_WIDTH-1:0] addw_read,
    output logic [DATA_WIDTH-1:0] din_read,
    output logic                  we_ref,
    output logic [ADDR_WIDTH-1:0] addw_ref,
    output logic [DATA_WIDTH-1:0] din_ref,
    output logic [N_MATRIX-1:0]   we_matrix,
    output logic [ADDR_WIDTH-1:0] addw_matrix,
    output logic [DATA_WIDTH-1:0] din_matrix,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(MEM_SIZE / 4);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_READ,
        LOAD_REF,
        CLEAR,
        FINISH
    } state_t;

    state_t state, next_state;

    logic [LEN_W-1:0] cnt, cnt_n;
    logic [LEN_W-1:0] rlen, rlen_n;
    logic [LEN_W-1:0] flen, flen_n;

    logic                  s_ready_d;
    logic                  we_read_d;
    logic [ADDR_WIDTH-1:0] addw_read_d;
    logic [DATA_WIDTH-1:0] din_read_d;
    logic                  we_ref_d;
    logic [ADDR_WIDTH-1:0] addw_ref_d;
    logic [DATA_WIDTH-1:0] din_ref_d;
    logic [N_MATRIX-1:0]   we_matrix_d;
    logic [ADDR_WIDTH-1:0] addw_matrix_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  error_d;
    logic                  hs;
    logic [ADDR_WIDTH-1:0] cnt_addr;

    assign hs       = s_valid & s_ready;
    assign cnt_addr = ADDR_WIDTH'({cnt, 2'b00});

    always_comb begin
        next_state    = state;
        cnt_n         = cnt;
        rlen_n        = rlen;
        flen_n        = flen;
        we_read_d     = 1'b0;
        addw_read_d   = addw_read;
        din_read_d    = din_read;
        we_ref_d      = 1'b0;
        addw_ref_d    = addw_ref;
        din_ref_d     = din_ref;
        we_matrix_d   = '0;
        addw_matrix_d = addw_matrix;
        done_d        = 1'b0;
        error_d       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (read_len > DEPTH || ref_len > DEPTH) begin
                        error_d = 1'b1;
                    end else begin
                        rlen_n     = read_len;
                        flen_n     = ref_len;
                        cnt_n      = '0;
                        next_state = LOAD_READ;
                    end
                end
            end
            LOAD_READ: begin
                if (rlen == '0) begin
                    next_state = LOAD_REF;
                end else if (hs) begin
                    we_read_d   = 1'b1;
                    addw_read_d = cnt_addr;
                    din_read_d  = s_data;
                    if (cnt == rlen - 1'b1) begin
                        cnt_n      = '0;
                        next_state = LOAD_REF;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            LOAD_REF: begin
                if (flen == '0) begin
                    cnt_n      = '0;
                    next_state = CLEAR;
                end else if (hs) begin
                    we_ref_d   = 1'b1;
                    addw_ref_d = cnt_addr;
                    din_ref_d  = s_data;
                    if (cnt == flen - 1'b1) begin
                        cnt_n      = '0;
                        next_state = CLEAR;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            CLEAR: begin
                we_matrix_d   = '1;
                addw_matrix_d = cnt_addr;
                if (cnt == DEPTH - 1'b1) begin
                    cnt_n      = '0;
                    next_state = FINISH;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            FINISH: begin
                done_d     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // ready follows the state being entered so there is no bubble
        s_ready_d = (next_state == LOAD_READ && rlen_n != '0) ||
                    (next_state == LOAD_REF  && flen_n != '0);
        busy_d    = (next_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rlen        <= '0;
            flen        <= '0;
            s_ready     <= 1'b0;
            we_read     <= 1'b0;
            addw_read   <= '0;
            din_read    <= '0;
            we_ref      <= 1'b0;
            addw_ref    <= '0;
            din_ref     <= '0;
            we_matrix   <= '0;
            addw_matrix <= '0;
            din_matrix  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_n;
            rlen        <= rlen_n;
            flen        <= flen_n;
            s_ready     <= s_ready_d;
            we_read     <= we_read_d;
            addw_read   <= addw_read_d;
            din_read    <= din_read_d;
            we_ref      <= we_ref_d;
            addw_ref    <= addw_ref_d;
            din_ref     <= din_ref_d;
            we_matrix   <= we_matrix_d;
            addw_matrix <= addw_matrix_d;
            din_matrix  <= '0;
            busy        <= busy_d;
            done        <= done_d;
            error       <= error_d;
        end
    end

endmodule

// File: tb/tb_dna_mem_loader.sv
// Directed bench for dna_mem_loader: load, stall, empty read,
// length error, start-while-busy and mid-run reset.
module tb_dna_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  read_len;
    logic [7:0]  ref_len;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        we_read;
    logic [31:0] addw_read;
    logic [31:0] din_read;
    logic        we_ref;
    logic [31:0] addw_ref;
    logic [31:0] din_ref;
    logic [15:0] we_matrix;
    logic [31:0] addw_matrix;
    logic [31:0] din_matrix;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    dna_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .read_len(read_len), .ref_len(ref_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .we_read(we_read), .addw_read(addw_read), .din_read(din_read),
        .we_ref(we_ref), .addw_ref(addw_ref), .din_ref(din_ref),
        .we_matrix(we_matrix), .addw_matrix(addw_matrix),
        .din_matrix(din_matrix),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // write log, filled on the falling edge
    logic [31:0] rd_a[$], rd_d[$], rf_a[$], rf_d[$], mx_a[$];
    int done_cnt, err_cnt, overlap_cnt, mx_bad, busy_done;
    logic clr_req = 1'b0;

    always @(negedge clk) begin
        if (clr_req) begin
            rd_a.delete(); rd_d.delete(); rf_a.delete(); rf_d.delete();
            mx_a.delete();
            done_cnt = 0; err_cnt = 0; overlap_cnt = 0;
            mx_bad = 0; busy_done = 0;
        end else if (rst_n) begin
            if (we_read) begin rd_a.push_back(addw_read); rd_d.push_back(din_read); end
            if (we_ref)  begin rf_a.push_back(addw_ref);  rf_d.push_back(din_ref);  end
            if (we_matrix != 16'h0) begin
                mx_a.push_back(addw_matrix);
                if (we_matrix !== 16'hffff || din_matrix !== 32'h0) mx_bad++;
            end
            if (int'(we_read) + int'(we_ref) + int'(we_matrix != 16'h0) > 1)
                overlap_cnt++;
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (done && busy) busy_done++;
        end
    end

    task automatic clear_log();
        clr_req = 1'b1;
        @(negedge clk);
        #1 clr_req = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] rl, input logic [7:0] fl);
        read_len = rl; ref_len = fl; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit tog, input logic [31:0] base);
        int i = 0;
        int cyc = 0;
        bit hs;
        while (i < n && cyc < 1000) begin
            s_valid = tog ? ~cyc[0] : 1'b1;
            s_data  = base + i;
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            if (hs) i++;
            cyc++;
        end
        s_valid = 1'b0;
        checks++;
        if (i != n) begin
            errors++;
            $display("FAIL feed_handshakes: got %0d want %0d", i, n);
        end
    endtask

    task automatic wait_done(input int want);
        int cyc = 0;
        while (done_cnt < want && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done_cnt < want) begin
            errors++;
            $display("FAIL done_timeout: got %0d want %0d", done_cnt, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; read_len = '0; ref_len = '0;
        s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ((|{s_ready, we_read, addw_read, din_read, we_ref, addw_ref,
               din_ref, we_matrix, addw_matrix, din_matrix,
               busy, done, error}) !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero want all 0");
        end
        @(posedge clk); #1 rst_n = 1'b1;
        clear_log();
    endtask

    task automatic test_basic();
        clear_log();
        do_start(8'd4, 8'd3);
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_ready: got %b%b want 11", busy, s_ready);
        end
        feed(7, 1'b0, 32'h10);
        wait_done(1);
        repeat (3) @(negedge clk);
        checks++;
        if (rd_a.size() != 4 || rf_a.size() != 3) begin
            errors++;
            $display("FAIL basic_counts: got rd=%0d rf=%0d want 4 3",
                     rd_a.size(), rf_a.size());
        end
        for (int k = 0; k < 4 && k < rd_a.size(); k++) begin
            checks++;
            if (rd_a[k] !== 32'(4 * k) || rd_d[k] !== 32'h10 + 32'(k)) begin
                errors++;
                $display("FAIL basic_read[%0d]: got %h/%h want %h/%h", k,
                         rd_a[k], rd_d[k], 4 * k, 32'h10 + 32'(k));
            end
        end
        for (int k = 0; k < 3 && k < rf_a.size(); k++) begin
            checks++;
            if (rf_a[k] !== 32'(4 * k) || rf_d[k] !== 32'h14 + 32'(k)) begin
                errors++;
                $display("FAIL basic_ref[%0d]: got %h/%h want %h/%h", k,
                         rf_a[k], rf_d[k], 4 * k, 32'h14 + 32'(k));
            end
        end
        checks++;
        if (mx_a.size() != 128 || mx_bad != 0) begin
            errors++;
            $display("FAIL basic_clear: got %0d writes bad=%0d want 128 0",
                     mx_a.size(), mx_bad);
        end
        for (int k = 0; k < mx_a.size(); k++) begin
            if (mx_a[k] !== 32'(4 * k)) begin
                checks++; errors++;
                $display("FAIL basic_clear_addr[%0d]: got %h want %h",
                         k, mx_a[k], 4 * k);
                break;
            end
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0 || busy_done != 0 || overlap_cnt != 0) begin
            errors++;
            $display("FAIL basic_end: got done=%0d busy=%b bd=%0d ov=%0d want 1 0 0 0",
                     done_cnt, busy, busy_done, overlap_cnt);
        end
    endtask

    task automatic test_stall();
        clear_log();
        do_start(8'd4, 8'd3);
        feed(7, 1'b1, 32'h10);
        wait_done(1);
        repeat (3) @(negedge clk);
        checks++;
        if (rd_a.size() != 4 || rf_a.size() != 3 || mx_a.size() != 128) begin
            errors++;
            $display("FAIL stall_counts: got %0d %0d %0d want 4 3 128",
                     rd_a.size(), rf_a.size(), mx_a.size());
        end
        for (int k = 0; k < 4 && k < rd_a.size(); k++) begin
            checks++;
            if (rd_a[k] !== 32'(4 * k) || rd_d[k] !== 32'h10 + 32'(k)) begin
                errors++;
                $display("FAIL stall_read[%0d]: got %h/%h", k, rd_a[k], rd_d[k]);
            end
        end
        for (int k = 0; k < 3 && k < rf_a.size(); k++) begin
            checks++;
            if (rf_a[k] !== 32'(4 * k) || rf_d[k] !== 32'h14 + 32'(k)) begin
                errors++;
                $display("FAIL stall_ref[%0d]: got %h/%h", k, rf_a[k], rf_d[k]);
            end
        end
        checks++;
        if (done_cnt != 1 || overlap_cnt != 0) begin
            errors++;
            $display("FAIL stall_end: got done=%0d ov=%0d want 1 0", done_cnt, overlap_cnt);
        end
    endtask

    task automatic test_zero_read();
        clear_log();
        do_start(8'd0, 8'd2);
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_first_cycle: got busy=%b rdy=%b want 1 0", busy, s_ready);
        end
        feed(2, 1'b0, 32'h55);
        wait_done(1);
        repeat (2) @(negedge clk);
        checks++;
        if (rd_a.size() != 0 || rf_a.size() != 2 || mx_a.size() != 128) begin
            errors++;
            $display("FAIL zero_counts: got %0d %0d %0d want 0 2 128",
                     rd_a.size(), rf_a.size(), mx_a.size());
        end else begin
            checks++;
            if (rf_a[0] !== 32'h0 || rf_a[1] !== 32'h4 ||
                rf_d[0] !== 32'h55 || rf_d[1] !== 32'h56) begin
                errors++;
                $display("FAIL zero_ref: got %h/%h %h/%h want 0/55 4/56",
                         rf_a[0], rf_d[0], rf_a[1], rf_d[1]);
            end
        end
    endtask

    task automatic test_len_error();
        clear_log();
        do_start(8'd129, 8'd1);
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: got err=%b busy=%b rdy=%b want 1 0 0",
                     error, busy, s_ready);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err_cnt != 1 || busy !== 1'b0 || rd_a.size() != 0 ||
            rf_a.size() != 0 || mx_a.size() != 0) begin
            errors++;
            $display("FAIL err_after: got errs=%0d busy=%b writes=%0d want 1 0 0",
                     err_cnt, busy, rd_a.size() + rf_a.size() + mx_a.size());
        end
    endtask

    task automatic test_start_in_clear();
        clear_log();
        do_start(8'd4, 8'd3);
        feed(7, 1'b0, 32'h10);
        repeat (10) @(negedge clk);
        #1;
        do_start(8'd4, 8'd4);
        wait_done(1);
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt != 1 || busy !== 1'b0 || rd_a.size() != 4 ||
            mx_a.size() != 128) begin
            errors++;
            $display("FAIL busy_start: got done=%0d busy=%b rd=%0d mx=%0d want 1 0 4 128",
                     done_cnt, busy, rd_a.size(), mx_a.size());
        end
    endtask

    task automatic test_mid_reset();
        clear_log();
        do_start(8'd4, 8'd4);
        feed(6, 1'b0, 32'h20);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ((|{s_ready, we_read, addw_read, din_read, we_ref, addw_ref,
               din_ref, we_matrix, addw_matrix, busy, done, error}) !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got nonzero want all 0");
        end
        @(posedge clk); #1 rst_n = 1'b1;
        clear_log();
        do_start(8'd2, 8'd1);
        feed(3, 1'b0, 32'h40);
        wait_done(1);
        checks++;
        if (rd_a.size() != 2 || rf_a.size() != 1) begin
            errors++;
            $display("FAIL midreset_counts: got %0d %0d want 2 1", rd_a.size(), rf_a.size());
        end else begin
            checks++;
            if (rd_a[0] !== 32'h0 || rd_d[0] !== 32'h40 ||
                rf_a[0] !== 32'h0 || rf_d[0] !== 32'h42) begin
                errors++;
                $display("FAIL midreset_restart: got %h/%h %h/%h want 0/40 0/42",
                         rd_a[0], rd_d[0], rf_a[0], rf_d[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_read();
        test_len_error();
        test_start_in_clear();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
